// File: rtl/ext_sbit_trigger_out.sv
// ---------------------------------------------------------------------------
// ext_sbit_trigger_out
//
// External (HDMI / front-panel) S-bit output controller. Every output bit
// picks one trigger source: a single VFAT S-bit OR, an eta partition, a
// sector, or a multiplicity coincidence. That source is edge-detected and
// fed to a per-output pulse-stretch / deadtime state machine. The result is
// a clean pulse of known width, followed by a guaranteed quiet period.
//
// Pipeline:
//   edge 1 : ors_q, eta_q, sector_q, mult_q (popcount) registered
//   edge 2 : raw_q per output (mode/selector mux), raw_prev = old raw_q
//   edge 3 : FSM reacts to trigger = raw_q & ~raw_prev, output registered
//
// Ports:
//   clock           in   40 MHz fabric clock
//   reset_n_i       in   synchronous reset, active-low
//   active_vfats_i  in   [NUM_VFATS]       per-VFAT S-bit OR
//   sbit_mode_i     in   [3*NUM_OUTPUTS]   per-output mode (0 vfat, 1 eta,
//                                          2 sector, 3 multiplicity, 4-7 off)
//   sbit_sel_i      in   [SEL_W*NUM_OUTPUTS]  per-output source selector
//   stretch_i       in   [TIME_W*NUM_OUTPUTS] extra high cycles per pulse
//   deadtime_i      in   [TIME_W*NUM_OUTPUTS] dead cycles after each pulse
//   mult_thresh_i   in   [SEL_W]           multiplicity threshold (0 = off)
//   ext_sbits_o     out  [NUM_OUTPUTS]     registered external outputs
//
// Optional build macro:
//   EXT_SBIT_RETRIGGER_EN - a trigger during STRETCH reloads the stretch
//   counter, so the pulse is extended. When undefined those triggers are
//   ignored.
//
// FSM state of output j is held in state_q[j] (cnt_q[j] holds its counter).
// ---------------------------------------------------------------------------
module ext_sbit_trigger_out #(
    parameter int NUM_VFATS   = 24,
    parameter int NUM_OUTPUTS = 8,
    parameter int NUM_ETA     = 8,
    parameter int NUM_SECTORS = 6,
    parameter int SEL_W       = 5,
    parameter int TIME_W      = 4
) (
    input  logic                          clock,
    input  logic                          reset_n_i,
    input  logic [NUM_VFATS-1:0]          active_vfats_i,
    input  logic [3*NUM_OUTPUTS-1:0]      sbit_mode_i,
    input  logic [SEL_W*NUM_OUTPUTS-1:0]  sbit_sel_i,
    input  logic [TIME_W*NUM_OUTPUTS-1:0] stretch_i,
    input  logic [TIME_W*NUM_OUTPUTS-1:0] deadtime_i,
    input  logic [SEL_W-1:0]              mult_thresh_i,
    output logic [NUM_OUTPUTS-1:0]        ext_sbits_o
);

    localparam int VFATS_PER_SECTOR = NUM_VFATS / NUM_SECTORS;
    localparam int MULT_W           = $clog2(NUM_VFATS + 1);
    // Common width for the multiplicity comparison so neither side truncates.
    localparam int CMP_W            = (MULT_W > SEL_W) ? MULT_W : SEL_W;

    // -----------------------------------------------------------------------
    // Stage 1: grouping and popcount of the raw VFAT ORs
    // -----------------------------------------------------------------------
    logic [NUM_VFATS-1:0]   ors_q;
    logic [NUM_ETA-1:0]     eta_d;
    logic [NUM_ETA-1:0]     eta_q;
    logic [NUM_SECTORS-1:0] sector_d;
    logic [NUM_SECTORS-1:0] sector_q;
    logic [MULT_W-1:0]      mult_d;
    logic [MULT_W-1:0]      mult_q;

    always_comb begin
        eta_d    = '0;
        sector_d = '0;
        mult_d   = '0;
        for (int v = 0; v < NUM_VFATS; v++) begin
            // Eta partitions interleave across VFATs; sectors are contiguous.
            eta_d[v % NUM_ETA] = eta_d[v % NUM_ETA] | active_vfats_i[v];
            sector_d[v / VFATS_PER_SECTOR] = sector_d[v / VFATS_PER_SECTOR] | active_vfats_i[v];
            mult_d = mult_d + MULT_W'(active_vfats_i[v]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n_i) begin
            ors_q    <= '0;
            eta_q    <= '0;
            sector_q <= '0;
            mult_q   <= '0;
        end else begin
            ors_q    <= active_vfats_i;
            eta_q    <= eta_d;
            sector_q <= sector_d;
            mult_q   <= mult_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: per-output source selection and edge detection
    // -----------------------------------------------------------------------
    logic                   mult_hit;
    logic [NUM_OUTPUTS-1:0] raw_d;
    logic [NUM_OUTPUTS-1:0] raw_q;
    logic [NUM_OUTPUTS-1:0] raw_prev;
    logic [NUM_OUTPUTS-1:0] trigger;

    // A zero threshold disables the coincidence rather than firing always.
    assign mult_hit = (mult_thresh_i != '0) &&
                      (CMP_W'(mult_q) >= CMP_W'(mult_thresh_i));

    // Selectors are compared against every legal index instead of being used
    // as a direct index, so an out-of-range selector simply matches nothing
    // and yields 0 without ever addressing past the end of a vector.
    always_comb begin
        raw_d = '0;
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            case (sbit_mode_i[3*j +: 3])
                3'd0: begin
                    for (int i = 0; i < NUM_VFATS; i++) begin
                        if (int'(sbit_sel_i[SEL_W*j +: SEL_W]) == i) begin
                            raw_d[j] = ors_q[i];
                        end
                    end
                end
                3'd1: begin
                    for (int i = 0; i < NUM_ETA; i++) begin
                        if (int'(sbit_sel_i[SEL_W*j +: SEL_W]) == i) begin
                            raw_d[j] = eta_q[i];
                        end
                    end
                end
                3'd2: begin
                    for (int i = 0; i < NUM_SECTORS; i++) begin
                        if (int'(sbit_sel_i[SEL_W*j +: SEL_W]) == i) begin
                            raw_d[j] = sector_q[i];
                        end
                    end
                end
                3'd3:    raw_d[j] = mult_hit;
                default: raw_d[j] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n_i) begin
            raw_q    <= '0;
            raw_prev <= '0;
        end else begin
            raw_q    <= raw_d;
            raw_prev <= raw_q;
        end
    end

    // Rising edge only: a level held high produces a single trigger.
    assign trigger = raw_q & ~raw_prev;

    // -----------------------------------------------------------------------
    // Stage 3: per-output pulse-stretch / deadtime FSM
    //   IDLE    -> STRETCH on trigger, cnt = stretch
    //   STRETCH -> high for stretch+1 cycles, then DEAD (or IDLE if no dead)
    //   DEAD    -> low for deadtime+1 cycles, triggers are discarded
    // The output register is written with the decoded next state so that it
    // is exactly (state == STRETCH) while still being a flop.
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_DEAD    = 2'd2
    } state_t;

    state_t                 state_q [NUM_OUTPUTS];
    logic [TIME_W-1:0]      cnt_q   [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] ext_q;

    always_ff @(posedge clock) begin
        if (!reset_n_i) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                state_q[j] <= ST_IDLE;
                cnt_q[j]   <= '0;
            end
            ext_q <= '0;
        end else begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                case (state_q[j])
                    ST_IDLE: begin
                        if (trigger[j]) begin
                            state_q[j] <= ST_STRETCH;
                            cnt_q[j]   <= stretch_i[TIME_W*j +: TIME_W];
                            ext_q[j]   <= 1'b1;
                        end else begin
                            ext_q[j]   <= 1'b0;
                        end
                    end

                    ST_STRETCH: begin
`ifdef EXT_SBIT_RETRIGGER_EN
                        if (trigger[j]) begin
                            // Reload keeps the output continuously high.
                            cnt_q[j] <= stretch_i[TIME_W*j +: TIME_W];
                            ext_q[j] <= 1'b1;
                        end else
`endif
                        if (cnt_q[j] == '0) begin
                            ext_q[j] <= 1'b0;
                            if (deadtime_i[TIME_W*j +: TIME_W] != '0) begin
                                state_q[j] <= ST_DEAD;
                                cnt_q[j]   <= deadtime_i[TIME_W*j +: TIME_W];
                            end else begin
                                state_q[j] <= ST_IDLE;
                            end
                        end else begin
                            cnt_q[j] <= cnt_q[j] - 1'b1;
                            ext_q[j] <= 1'b1;
                        end
                    end

                    ST_DEAD: begin
                        // The edge that leaves DEAD is still a DEAD edge, so
                        // a trigger arriving there is dropped as well.
                        ext_q[j] <= 1'b0;
                        if (cnt_q[j] == '0) begin
                            state_q[j] <= ST_IDLE;
                        end else begin
                            cnt_q[j] <= cnt_q[j] - 1'b1;
                        end
                    end

                    default: begin
                        state_q[j] <= ST_IDLE;
                        cnt_q[j]   <= '0;
                        ext_q[j]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ext_sbits_o = ext_q;

endmodule

// File: tb/tb_ext_sbit_trigger_out.sv
// ---------------------------------------------------------------------------
// tb_ext_sbit_trigger_out
//
// Directed bench for ext_sbit_trigger_out with default parameters
// (24 VFATs, 8 outputs, 8 eta partitions, 6 sectors of 4 VFATs).
// Inputs are driven 1 time unit after a rising edge, so they are sampled at
// the following edge; outputs are sampled at that same point, i.e. after
// the edge that produced them.
// ---------------------------------------------------------------------------
module tb_ext_sbit_trigger_out;

    localparam int NV = 24;
    localparam int NO = 8;
    localparam int SW = 5;
    localparam int TW = 4;

    // Clock / reset
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // DUT stimulus
    logic [NV-1:0]    vfats;
    logic [3*NO-1:0]  mode_v;
    logic [SW*NO-1:0] sel_v;
    logic [TW*NO-1:0] st_v;
    logic [TW*NO-1:0] dt_v;
    logic [SW-1:0]    thresh;
    logic [NO-1:0]    ext;

    ext_sbit_trigger_out dut (
        .clock          (clock),
        .reset_n_i      (reset_n),
        .active_vfats_i (vfats),
        .sbit_mode_i    (mode_v),
        .sbit_sel_i     (sel_v),
        .stretch_i      (st_v),
        .deadtime_i     (dt_v),
        .mult_thresh_i  (thresh),
        .ext_sbits_o    (ext)
    );

    // Result bookkeeping
    int checks = 0;
    int fails  = 0;

    // Per-output activity observed over a measurement window
    int   hi_cnt   [NO];
    int   rise_cnt [NO];
    int   run_len  [NO];
    int   max_run  [NO];
    logic prev_out [NO];

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic all_off();
        mode_v = {NO{3'd7}};
        sel_v  = '0;
        st_v   = '0;
        dt_v   = '0;
        thresh = '0;
    endtask

    task automatic set_cfg(input int j, input logic [2:0] m, input logic [SW-1:0] s,
                           input logic [TW-1:0] st, input logic [TW-1:0] dt);
        mode_v[3*j +: 3]   = m;
        sel_v[SW*j +: SW]  = s;
        st_v[TW*j +: TW]   = st;
        dt_v[TW*j +: TW]   = dt;
    endtask

    task automatic clear_counts();
        for (int j = 0; j < NO; j++) begin
            hi_cnt[j]   = 0;
            rise_cnt[j] = 0;
            run_len[j]  = 0;
            max_run[j]  = 0;
            prev_out[j] = ext[j];
        end
    endtask

    // Advance n edges, sampling outputs just after each edge.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            for (int j = 0; j < NO; j++) begin
                if (ext[j]) begin
                    hi_cnt[j]++;
                    run_len[j]++;
                    if (run_len[j] > max_run[j]) max_run[j] = run_len[j];
                    if (!prev_out[j]) rise_cnt[j]++;
                end else begin
                    run_len[j] = 0;
                end
                prev_out[j] = ext[j];
            end
        end
    endtask

    task automatic idle(input int n);
        vfats = '0;
        run_cycles(n);
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        vfats   = '1;
        mode_v  = '0;
        sel_v   = '0;
        st_v    = '1;
        dt_v    = '0;
        thresh  = 5'd1;
        clear_counts();
        for (int k = 0; k < 5; k++) begin
            run_cycles(1);
            checks++;
            if (ext !== 8'h00) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: ext=%h expected 00", k, ext);
            end
        end
        all_off();
        vfats   = '0;
        reset_n = 1'b1;
        clear_counts();
        run_cycles(6);
        checks++;
        if (rise_cnt[0] + rise_cnt[1] + rise_cnt[7] !== 0 || ext !== 8'h00) begin
            fails++;
            $display("FAIL reset_release: ext=%h expected 00", ext);
        end
    endtask

    task automatic test_latency();
        logic [NO-1:0] seen [4];
        all_off();
        set_cfg(0, 3'd0, 5'd3, 4'd0, 4'd0);
        run_cycles(2);
        vfats = 24'h000008;
        for (int k = 0; k < 4; k++) begin
            run_cycles(1);
            seen[k] = ext;
        end
        checks++;
        if (seen[0][0] !== 1'b0 || seen[1][0] !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: out0 after +1=%b +2=%b expected 0 0", seen[0][0], seen[1][0]);
        end
        checks++;
        if (seen[2][0] !== 1'b1) begin
            fails++;
            $display("FAIL latency_high: out0 after +3=%b expected 1", seen[2][0]);
        end
        checks++;
        if (seen[3][0] !== 1'b0) begin
            fails++;
            $display("FAIL latency_width: out0 after +4=%b expected 0", seen[3][0]);
        end
        clear_counts();
        run_cycles(12);
        checks++;
        if (hi_cnt[0] !== 0) begin
            fails++;
            $display("FAIL held_level: out0 high cycles=%0d expected 0", hi_cnt[0]);
        end
        idle(8);
    endtask

    task automatic test_eta_sector();
        all_off();
        set_cfg(1, 3'd1, 5'd2, 4'd0, 4'd0);
        set_cfg(2, 3'd2, 5'd4, 4'd0, 4'd0);
        run_cycles(2);
        // VFAT 18: eta 2, sector 4
        clear_counts();
        vfats = 24'h1 << 18;
        run_cycles(3);
        idle(6);
        checks++;
        if (rise_cnt[1] !== 1 || rise_cnt[2] !== 1) begin
            fails++;
            $display("FAIL vfat18: out1 pulses=%0d out2 pulses=%0d expected 1 1", rise_cnt[1], rise_cnt[2]);
        end
        // VFAT 17: eta 1, sector 4
        clear_counts();
        vfats = 24'h1 << 17;
        run_cycles(3);
        idle(6);
        checks++;
        if (rise_cnt[1] !== 0 || rise_cnt[2] !== 1) begin
            fails++;
            $display("FAIL vfat17: out1 pulses=%0d out2 pulses=%0d expected 0 1", rise_cnt[1], rise_cnt[2]);
        end
        // VFAT 15: eta 7, sector 3
        clear_counts();
        vfats = 24'h1 << 15;
        run_cycles(3);
        idle(6);
        checks++;
        if (rise_cnt[1] !== 0 || rise_cnt[2] !== 0) begin
            fails++;
            $display("FAIL vfat15: out1 pulses=%0d out2 pulses=%0d expected 0 0", rise_cnt[1], rise_cnt[2]);
        end
        // Sector selector 9 is out of range
        set_cfg(2, 3'd2, 5'd9, 4'd0, 4'd0);
        run_cycles(2);
        clear_counts();
        vfats = '1;
        run_cycles(4);
        idle(6);
        checks++;
        if (rise_cnt[2] !== 0 || rise_cnt[1] !== 1) begin
            fails++;
            $display("FAIL sel_range: out2 pulses=%0d out1 pulses=%0d expected 0 1", rise_cnt[2], rise_cnt[1]);
        end
    endtask

    task automatic test_multiplicity();
        all_off();
        set_cfg(3, 3'd3, 5'd0, 4'd0, 4'd0);
        thresh = 5'd3;
        run_cycles(2);
        clear_counts();
        vfats = 24'h000003;
        run_cycles(8);
        checks++;
        if (rise_cnt[3] !== 0) begin
            fails++;
            $display("FAIL mult_two: out3 pulses=%0d expected 0", rise_cnt[3]);
        end
        clear_counts();
        vfats = 24'h000007;
        run_cycles(8);
        checks++;
        if (rise_cnt[3] !== 1 || hi_cnt[3] !== 1) begin
            fails++;
            $display("FAIL mult_three: out3 pulses=%0d high=%0d expected 1 1", rise_cnt[3], hi_cnt[3]);
        end
        idle(6);
        thresh = 5'd0;
        run_cycles(2);
        clear_counts();
        vfats = '1;
        run_cycles(8);
        checks++;
        if (rise_cnt[3] !== 0) begin
            fails++;
            $display("FAIL mult_zero_thresh: out3 pulses=%0d expected 0", rise_cnt[3]);
        end
        idle(6);
    endtask

    task automatic test_stretch_dead();
        int exp_rise;
        int exp_hi;
        int exp_run;
        all_off();
        set_cfg(4, 3'd0, 5'd5, 4'd3, 4'd4);
        run_cycles(2);
        clear_counts();
        // Rising input edge every 4 cycles; each pulse occupies 4 high plus
        // 5 dead cycles, so only every third edge survives.
        for (int s = 0; s < 48; s++) begin
            vfats = ((s / 2) % 2 == 0) ? (24'h1 << 5) : 24'h0;
            run_cycles(1);
        end
        idle(16);
`ifdef EXT_SBIT_RETRIGGER_EN
        exp_rise = 1;
        exp_hi   = 48;
        exp_run  = 48;
`else
        exp_rise = 4;
        exp_hi   = 16;
        exp_run  = 4;
`endif
        checks++;
        if (rise_cnt[4] !== exp_rise) begin
            fails++;
            $display("FAIL stretch_pulses: out4 pulses=%0d expected %0d", rise_cnt[4], exp_rise);
        end
        checks++;
        if (hi_cnt[4] !== exp_hi || max_run[4] !== exp_run) begin
            fails++;
            $display("FAIL stretch_width: out4 high=%0d longest=%0d expected %0d %0d",
                     hi_cnt[4], max_run[4], exp_hi, exp_run);
        end
    endtask

    task automatic test_retrigger();
        int exp_hi;
        all_off();
        set_cfg(6, 3'd0, 5'd9, 4'd3, 4'd0);
        run_cycles(2);
        clear_counts();
        // Triggers reach the FSM 3 edges apart: second one lands in STRETCH.
        vfats = 24'h1 << 9;
        run_cycles(1);
        vfats = 24'h0;
        run_cycles(2);
        vfats = 24'h1 << 9;
        run_cycles(1);
        idle(14);
`ifdef EXT_SBIT_RETRIGGER_EN
        exp_hi = 7;
`else
        exp_hi = 4;
`endif
        checks++;
        if (rise_cnt[6] !== 1 || max_run[6] !== exp_hi || hi_cnt[6] !== exp_hi) begin
            fails++;
            $display("FAIL retrigger: out6 pulses=%0d longest=%0d high=%0d expected 1 %0d %0d",
                     rise_cnt[6], max_run[6], hi_cnt[6], exp_hi, exp_hi);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int guard;
        all_off();
        set_cfg(5, 3'd0, 5'd7, 4'd15, 4'd0);
        run_cycles(2);
        clear_counts();
        vfats = 24'h1 << 7;
        guard = 0;
        while (hi_cnt[5] < 5 && guard < 20) begin
            run_cycles(1);
            guard++;
        end
        checks++;
        if (hi_cnt[5] !== 5) begin
            fails++;
            $display("FAIL midpulse_reach: out5 high=%0d expected 5 within 20 cycles", hi_cnt[5]);
        end
        reset_n = 1'b0;
        run_cycles(1);
        checks++;
        if (ext[5] !== 1'b0) begin
            fails++;
            $display("FAIL midpulse_reset: out5=%b expected 0", ext[5]);
        end
        vfats = '0;
        run_cycles(2);
        reset_n = 1'b1;
        run_cycles(3);
        clear_counts();
        vfats = 24'h1 << 7;
        run_cycles(25);
        checks++;
        if (rise_cnt[5] !== 1 || hi_cnt[5] !== 16 || max_run[5] !== 16) begin
            fails++;
            $display("FAIL post_reset_pulse: out5 pulses=%0d high=%0d longest=%0d expected 1 16 16",
                     rise_cnt[5], hi_cnt[5], max_run[5]);
        end
        idle(4);
    endtask

    // -----------------------------------------------------------------------
    // Sequence and final report
    // -----------------------------------------------------------------------
    initial begin
        reset_n = 1'b0;
        vfats   = '0;
        all_off();
        test_reset();
        test_latency();
        test_eta_sector();
        test_multiplicity();
        test_stretch_dead();
        test_retrigger();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
